// File: rtl/pipelined_control_unit_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, control-word
// bit positions, FSM state type and the illegal-opcode helper.
package pipelined_control_unit_pkg;

    localparam int CTRL_W = 22;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3,
        OP_MOD  = 5'd4,  OP_CMP  = 5'd5,  OP_AND  = 5'd6,  OP_OR   = 5'd7,
        OP_NOT  = 5'd8,  OP_MOV  = 5'd9,  OP_LSL  = 5'd10, OP_LSR  = 5'd11,
        OP_ASR  = 5'd12, OP_NOP  = 5'd13, OP_LD   = 5'd14, OP_ST   = 5'd15,
        OP_BEQ  = 5'd16, OP_BGT  = 5'd17, OP_B    = 5'd18, OP_CALL = 5'd19,
        OP_RET  = 5'd20
    } opcode_e;

    // Control word bit positions, isSt at bit 0 through isMov at bit 21
    localparam int IS_ST      = 0;
    localparam int IS_LD      = 1;
    localparam int IS_BEQ     = 2;
    localparam int IS_BGT     = 3;
    localparam int IS_RET     = 4;
    localparam int IS_IMM     = 5;
    localparam int IS_WB      = 6;
    localparam int IS_UBRANCH = 7;
    localparam int IS_CALL    = 8;
    localparam int IS_ADD     = 9;
    localparam int IS_SUB     = 10;
    localparam int IS_CMP     = 11;
    localparam int IS_MUL     = 12;
    localparam int IS_DIV     = 13;
    localparam int IS_MOD     = 14;
    localparam int IS_LSL     = 15;
    localparam int IS_LSR     = 16;
    localparam int IS_ASR     = 17;
    localparam int IS_OR      = 18;
    localparam int IS_AND     = 19;
    localparam int IS_NOT     = 20;
    localparam int IS_MOV     = 21;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic logic is_illegal_op(input logic [4:0] op);
        return op > 5'd20;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Purely combinational opcode/immediate-bit to control-word decoder.
module cu_decode
    import pipelined_control_unit_pkg::*;
(
    input  logic [4:0]        opcode,
    input  logic              imm,
    output logic [CTRL_W-1:0] ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl[IS_IMM] = imm;
        case (opcode_e'(opcode))
            OP_ADD:  begin ctrl[IS_ADD] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_SUB:  begin ctrl[IS_SUB] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_MUL:  begin ctrl[IS_MUL] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_DIV:  begin ctrl[IS_DIV] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_MOD:  begin ctrl[IS_MOD] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_CMP:  ctrl[IS_CMP] = 1'b1;
            OP_AND:  begin ctrl[IS_AND] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_OR:   begin ctrl[IS_OR]  = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_NOT:  begin ctrl[IS_NOT] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_MOV:  begin ctrl[IS_MOV] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_LSL:  begin ctrl[IS_LSL] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_LSR:  begin ctrl[IS_LSR] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_ASR:  begin ctrl[IS_ASR] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_NOP:  ;
            // Memory ops reuse the adder for address generation
            OP_LD:   begin ctrl[IS_LD] = 1'b1; ctrl[IS_ADD] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_ST:   begin ctrl[IS_ST] = 1'b1; ctrl[IS_ADD] = 1'b1; end
            OP_BEQ:  ctrl[IS_BEQ] = 1'b1;
            OP_BGT:  ctrl[IS_BGT] = 1'b1;
            OP_B:    ctrl[IS_UBRANCH] = 1'b1;
            OP_CALL: begin ctrl[IS_CALL] = 1'b1; ctrl[IS_UBRANCH] = 1'b1; ctrl[IS_WB] = 1'b1; end
            OP_RET:  begin ctrl[IS_RET] = 1'b1; ctrl[IS_UBRANCH] = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// One-entry control-word stage with multi-cycle hold for mul/div/mod.
// Define CU_ILLEGAL_TRAP_EN to get a registered illegal-opcode flag.
module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter int INSN_W  = 32,
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] insn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic              busy,
    output logic              illegal
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    logic [4:0]        opcode;
    logic              imm_bit;
    logic              unused_insn_bits;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [CNT_W-1:0]  lat_cnt;
    logic              load;

    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;

    assign opcode           = insn[INSN_W-1 -: 5];
    assign imm_bit          = insn[INSN_W-6];
    assign unused_insn_bits = ^insn[INSN_W-7:0];

    cu_decode u_decode (
        .opcode (opcode),
        .imm    (imm_bit),
        .ctrl   (dec_ctrl)
    );

    // Extra cycles beyond the first; zero means straight to FULL
    always_comb begin
        lat_cnt = '0;
        case (opcode_e'(opcode))
            OP_MUL:         lat_cnt = MUL_CNT;
            OP_DIV, OP_MOD: lat_cnt = DIV_CNT;
            default:        lat_cnt = '0;
        endcase
    end

    assign in_ready  = (state_reg == ST_EMPTY) | ((state_reg == ST_FULL) & out_ready);
    assign out_valid = (state_reg == ST_FULL);
    assign busy      = (state_reg == ST_WAIT);
    assign ctrl      = ctrl_reg;

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_reg, illegal_next;
    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ctrl_next  = ctrl_reg;
        load       = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal_next = illegal_reg;
`endif
        if (flush) begin
            state_next = ST_EMPTY;
            cnt_next   = '0;
            ctrl_next  = '0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_next = 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_EMPTY: load = in_valid;
                ST_WAIT: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = ST_FULL;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) load = 1'b1;
                        else          state_next = ST_EMPTY;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase

            if (load) begin
                ctrl_next = dec_ctrl;
`ifdef CU_ILLEGAL_TRAP_EN
                illegal_next = is_illegal_op(opcode);
`endif
                if (lat_cnt != '0) begin
                    state_next = ST_WAIT;
                    cnt_next   = lat_cnt;
                end else begin
                    state_next = ST_FULL;
                    cnt_next   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            cnt_reg   <= '0;
            ctrl_reg  <= '0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ctrl_reg  <= ctrl_next;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_reg <= illegal_next;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench: decode table, hand-written timing sequences and a
// randomized run against a timing/decode reference model.
module tb_pipelined_control_unit;
    import pipelined_control_unit_pkg::*;

    localparam int INSN_W  = 32;
    localparam int MUL_LAT = 1;
    localparam int DIV_LAT = 4;
`ifdef CU_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [INSN_W-1:0] insn = '0;
    logic              in_ready, out_valid, busy, illegal;
    logic [CTRL_W-1:0] ctrl;

    int checks = 0;
    int errors = 0;

    pipelined_control_unit #(
        .INSN_W  (INSN_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .insn      (insn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl      (ctrl),
        .busy      (busy),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CTRL_W-1:0] m(input int b);
        return CTRL_W'(1) << b;
    endfunction

    function automatic logic [INSN_W-1:0] mk(input int op, input bit i);
        logic [INSN_W-1:0] w;
        logic [4:0]        o;
        o = op[4:0];
        w = INSN_W'($urandom);
        w[INSN_W-1 -: 5] = o;
        w[INSN_W-6] = i;
        return w;
    endfunction

    // Decode rules: one own bit per op, then the shared adder/branch/writeback rules
    function automatic logic [CTRL_W-1:0] ref_ctrl(input int op, input bit i);
        logic [CTRL_W-1:0] r;
        int own [0:20];
        own = '{IS_ADD, IS_SUB, IS_MUL, IS_DIV, IS_MOD, IS_CMP, IS_AND, IS_OR,
                IS_NOT, IS_MOV, IS_LSL, IS_LSR, IS_ASR, -1, IS_LD, IS_ST,
                IS_BEQ, IS_BGT, -1, IS_CALL, IS_RET};
        r = '0;
        r[IS_IMM] = i;
        if (op > 20) return r;
        if (own[op] >= 0) r[own[op]] = 1'b1;
        if (op == 14 || op == 15) r[IS_ADD] = 1'b1;
        if (op >= 18) r[IS_UBRANCH] = 1'b1;
        if ((op <= 12 && op != 5) || op == 14 || op == 19) r[IS_WB] = 1'b1;
        return r;
    endfunction

    function automatic int ref_lat(input int op);
        if (op == 2) return MUL_LAT;
        if (op == 3 || op == 4) return DIV_LAT;
        return 1;
    endfunction

    typedef struct {
        int                op;
        bit                imm;
        logic [CTRL_W-1:0] exp;
    } vec_t;

    vec_t tbl [0:20];

    // reference model state for the random run
    bit                m_hold;
    int                m_ready_at;
    logic [CTRL_W-1:0] m_ctrl;
    bit                m_ill;
    int                now;
    bit                e_valid, e_busy, e_ready;
    int                r_op;
    bit                r_imm;
    int                lat;
    int                vcount;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,  1'b0, m(IS_ADD) | m(IS_WB)};
        tbl[1]  = '{1,  1'b0, m(IS_SUB) | m(IS_WB)};
        tbl[2]  = '{2,  1'b0, m(IS_MUL) | m(IS_WB)};
        tbl[3]  = '{3,  1'b0, m(IS_DIV) | m(IS_WB)};
        tbl[4]  = '{4,  1'b0, m(IS_MOD) | m(IS_WB)};
        tbl[5]  = '{5,  1'b0, m(IS_CMP)};
        tbl[6]  = '{6,  1'b0, m(IS_AND) | m(IS_WB)};
        tbl[7]  = '{7,  1'b0, m(IS_OR)  | m(IS_WB)};
        tbl[8]  = '{8,  1'b0, m(IS_NOT) | m(IS_WB)};
        tbl[9]  = '{9,  1'b0, m(IS_MOV) | m(IS_WB)};
        tbl[10] = '{10, 1'b0, m(IS_LSL) | m(IS_WB)};
        tbl[11] = '{11, 1'b0, m(IS_LSR) | m(IS_WB)};
        tbl[12] = '{12, 1'b0, m(IS_ASR) | m(IS_WB)};
        tbl[13] = '{13, 1'b0, '0};
        tbl[14] = '{14, 1'b0, m(IS_LD) | m(IS_ADD) | m(IS_WB)};
        tbl[15] = '{15, 1'b0, m(IS_ST) | m(IS_ADD)};
        tbl[16] = '{16, 1'b0, m(IS_BEQ)};
        tbl[17] = '{17, 1'b0, m(IS_BGT)};
        tbl[18] = '{18, 1'b0, m(IS_UBRANCH)};
        tbl[19] = '{19, 1'b0, m(IS_CALL) | m(IS_UBRANCH) | m(IS_WB)};
        tbl[20] = '{20, 1'b0, m(IS_RET) | m(IS_UBRANCH)};

        // reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_ctrl",      32'(ctrl),      32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // decode table, one instruction at a time
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; insn = mk(tbl[k].op, tbl[k].imm);
            #1;
            check($sformatf("tbl%0d_in_ready", k), 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                #1;
                lat++;
            end
            check($sformatf("tbl%0d_lat", k), 32'(lat), 32'(ref_lat(tbl[k].op)));
            check($sformatf("tbl%0d_ctrl", k), 32'(ctrl), 32'(tbl[k].exp));
            $display("table op=%0d ctrl=%06h lat=%0d", tbl[k].op, ctrl, lat);
        end
        @(posedge clk);

        // div latency: busy cycles 1..3, valid at cycle 4
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; insn = mk(3, 1'b0);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("div_c%0d_busy", c),      32'(busy),      32'(c < 4));
            check($sformatf("div_c%0d_in_ready", c),  32'(in_ready),  32'(c == 4));
            check($sformatf("div_c%0d_out_valid", c), 32'(out_valid), 32'(c == 4));
        end
        check("div_isdiv", 32'(ctrl[IS_DIV]), 32'd1);
        $display("seq div done");
        @(posedge clk);

        // add then sub back-to-back, no bubble
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; insn = mk(0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        insn = mk(1, 1'b0);
        #1;
        check("b2b_add_valid", 32'(out_valid), 32'd1);
        check("b2b_add_ctrl",  32'(ctrl),      32'(ref_ctrl(0, 1'b0)));
        check("b2b_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("b2b_sub_valid", 32'(out_valid), 32'd1);
        check("b2b_sub_ctrl",  32'(ctrl),      32'(ref_ctrl(1, 1'b0)));
        @(posedge clk);

        // sub held while out_ready is low
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; insn = mk(0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        insn = mk(1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d_valid", c),    32'(out_valid), 32'd1);
            check($sformatf("hold%0d_ctrl", c),     32'(ctrl),      32'(ref_ctrl(1, 1'b1)));
            check($sformatf("hold%0d_in_ready", c), 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("hold_release_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        #1;
        check("hold_drained", 32'(out_valid), 32'd0);
        $display("seq back-to-back done");

        // flush during mod WAIT with add presented
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; insn = mk(4, 1'b0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; insn = mk(0, 1'b0);
        #1;
        check("flush_pre_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_valid",    32'(out_valid), 32'd0);
        check("flush_busy",     32'(busy),      32'd0);
        check("flush_in_ready", 32'(in_ready),  32'd1);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) vcount++;
        end
        check("flush_no_emit", 32'(vcount), 32'd0);
        $display("seq flush done");

        // illegal opcode 5'b10110, then a legal op clears the flag
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; insn = mk(22, 1'b0);
        @(posedge clk);
        @(negedge clk);
        insn = mk(0, 1'b0);
        #1;
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_ctrl",  32'(ctrl),      32'd0);
        check("ill_flag",  32'(illegal),   32'(TRAP_EN));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("ill_clear", 32'(illegal), 32'd0);
        @(posedge clk);

        // asynchronous reset in the middle of a div WAIT
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; insn = mk(3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("arst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy",    32'(busy),      32'd0);
        check("arst_valid",   32'(out_valid), 32'd0);
        check("arst_ctrl",    32'(ctrl),      32'd0);
        check("arst_illegal", 32'(illegal),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("seq async reset done");

        // randomized run against the reference model
        m_hold = 1'b0; m_ready_at = 0; m_ctrl = '0; m_ill = 1'b0; now = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            r_op      = int'($urandom_range(0, 31));
            r_imm     = bit'($urandom_range(0, 1));
            insn      = mk(r_op, r_imm);
            #1;
            e_valid = m_hold && (now >= m_ready_at);
            e_busy  = m_hold && (now < m_ready_at);
            e_ready = !m_hold || (e_valid && out_ready);
            check("rnd_valid",    32'(out_valid), 32'(e_valid));
            check("rnd_busy",     32'(busy),      32'(e_busy));
            check("rnd_in_ready", 32'(in_ready),  32'(e_ready));
            check("rnd_illegal",  32'(illegal),   32'(TRAP_EN && m_ill));
            if (e_valid) check("rnd_ctrl", 32'(ctrl), 32'(m_ctrl));
            @(posedge clk);
            if (flush) begin
                m_hold = 1'b0;
                m_ill  = 1'b0;
            end else begin
                if (e_valid && out_ready) m_hold = 1'b0;
                if (in_valid && e_ready) begin
                    m_hold     = 1'b1;
                    m_ready_at = now + ref_lat(r_op);
                    m_ctrl     = ref_ctrl(r_op, r_imm);
                    m_ill      = (r_op > 20);
                    $display("rand capture op=%0d imm=%0d lat=%0d", r_op, r_imm, ref_lat(r_op));
                end
            end
            now++;
        end
        flush = 1'b0; in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  INSN_W, 32, instruction width; opcode = insn[INSN_W-1 -: 5], I bit = insn[INSN_W-6].
  MUL_LAT, 1, cycles from capture to out_valid for mul (>=1).
  DIV_LAT, 4, cycles from capture to out_valid for div and mod (>=1).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  flush  in  1  discard held and incoming instruction.
  in_valid  in  1  insn present.
  in_ready  out  1  block accepts insn this cycle.
  insn  in  INSN_W  instruction word.
  out_valid  out  1  ctrl valid.
  out_ready  in  1  consumer accepts ctrl.
  ctrl  out  22  packed control word, bit order per package (isSt..isMov).
  busy  out  1  multi-cycle op in progress.
  illegal  out  1  opcode 21..31 flag (CU_ILLEGAL_TRAP_EN only, else tied 0).
REQ-003 Clocking SHALL be one clock; reset asynchronous, active-low.

Function
REQ-004 Opcodes 0..20 SHALL decode as add,sub,mul,div,mod,cmp,and,or,not,mov,lsl,lsr,asr,nop,ld,st,beq,bgt,b,call,ret; one isX bit per op, isImmediate = I.
REQ-005 isAdd SHALL also assert for ld and st; isUBranch for b, call, ret; isCall for call only.
REQ-006 isWb SHALL assert for all ALU ops except cmp, plus ld and call; never for nop, st, beq, bgt, b, ret.
REQ-007 FSM states SHALL be EMPTY, WAIT, FULL; in_ready = EMPTY or (FULL and out_ready).
REQ-008 Capture (in_valid & in_ready) at edge T SHALL register ctrl; latency L=1 -> FULL, out_valid at T+1; L>1 -> WAIT, counter=L-1, busy=1.
REQ-009 WAIT SHALL decrement the counter each cycle, ctrl stable, out_valid=0, in_ready=0; counter reaching 0 -> FULL, out_valid at T+L.
REQ-010 FULL with out_ready & in_valid SHALL capture back-to-back (zero bubble); out_ready & !in_valid -> EMPTY; !out_ready holds ctrl and out_valid stable.
REQ-011 flush SHALL take priority over every event: next state EMPTY, counter 0, busy 0, out_valid 0, same-cycle insn discarded.
REQ-012 Opcodes 21..31 SHALL decode as all-zero ctrl (isImmediate still = I), treated as L=1.

Reset
REQ-013 rst_n low SHALL immediately force EMPTY, ctrl=0, out_valid=0, busy=0, illegal=0, counter=0, including mid-WAIT.
REQ-014 First capture after reset release SHALL occur no earlier than the first clk edge with rst_n high.

Configuration
REQ-015 With CU_ILLEGAL_TRAP_EN defined, illegal SHALL register 1 with ctrl for opcodes 21..31 and clear on next capture, flush or reset; without it illegal is constant 0 and no flop exists.

Structure
REQ-016 Shared package SHALL hold the opcode enum, ctrl bit-index constants, CTRL_W=22 and the FSM state type.
REQ-017 Combinational decode SHALL be a sub-module cu_decode (opcode, I -> ctrl); FSM, counter and handshake live in the top.

Verification
REQ-018 Reset, then stream opcodes 0..20 with I=0, out_ready=1, MUL_LAT=1 -> each ctrl matches REQ-004..006; ld gives isLd=isAdd=isWb=1; nop gives ctrl=0.
REQ-019 div with DIV_LAT=4 captured at cycle 0 -> busy 1 in cycles 1..3, in_ready 0, out_valid rises at cycle 4 with isDiv=1.
REQ-020 add then sub back-to-back, out_ready=1 -> out_valid continuous two cycles, no bubble; with out_ready=0 on sub, ctrl held unchanged until released.
REQ-021 flush asserted during WAIT of mod, in_valid=1 with add -> next cycle EMPTY, out_valid=0, busy=0, add not emitted.
REQ-022 rst_n pulsed low mid-WAIT -> all outputs 0 asynchronously; opcode 5'b10110 with CU_ILLEGAL_TRAP_EN -> illegal=1, ctrl=0; without macro -> illegal=0.
